shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that sequences the ALU's 8-bit, 3-bit-amount barrel shifters (left, right with fill bit, right rotate) to execute shifts with a full 8-bit shift amount. It accepts one request through a START/BUSY/DONE handshake and chains barrel passes of at most 7 positions per cycle until the requested amount is consumed. It sits beside the ALU and drives the CPU's stall logic via BUSY for `sll`/`srl`/`sra`/`ror` instructions with register-sourced amounts.

## Interface

Parameters:
- none (datapath fixed at 8 bits, per-pass step fixed at 0..7)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high; dominates all other inputs
- START  input  1  request strobe, sampled only in IDLE
- OP  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled with START
- DATA  input  8  operand; sampled with START
- AMOUNT  input  8  unsigned shift amount 0..255; sampled with START
- BUSY  output  1  high in SHIFT and DONE states
- DONE  output  1  one-cycle completion pulse
- RESULT  output  8  registered shift result; holds until next accepted request
- ZERO  output  1  registered, RESULT == 8'h00

## Operation

- State register: IDLE, SHIFT, DONE.
- Internal registers: ACC[7:0], REM[7:0], OPR[1:0].
- IDLE: BUSY=0, DONE=0. START=1 at an edge → ACC←DATA, OPR←OP, REM←AMOUNT (OP=ROR: REM←{5'b0, AMOUNT[2:0]}), state→SHIFT. START=0 → stay.
- SHIFT: STEP = (REM > 7) ? 3'd7 : REM[2:0]. Each edge: ACC←pass(ACC, STEP), REM←REM−STEP.
  - SLL: left barrel shift, zero fill.
  - SRL: right barrel shift, fill bit 0.
  - SRA: right barrel shift, fill bit = ACC[7] of the current pass (sign preserved across passes).
  - ROR: right rotate.
  - If REM−STEP == 0: RESULT←pass result, ZERO←(pass result == 0), state→DONE. Otherwise stay in SHIFT.
  - AMOUNT=0 takes one SHIFT cycle with STEP=0, so RESULT=DATA.
- DONE: DONE=1, BUSY=1 for exactly one cycle, then state→IDLE unconditionally. START in DONE is ignored, not queued.
- START during SHIFT/DONE: ignored; operand inputs are don't-care outside IDLE.
- No early termination: logical shifts with large amounts still run every pass. Result saturation (0x00, or all sign bits) falls out of the arithmetic.
- RESET: state←IDLE, ACC←0, REM←0, OPR←0, RESULT←0, ZERO←1, BUSY←0, DONE←0. Reset mid-operation aborts with no DONE pulse. A START coincident with RESET is dropped.

## Timing

- Pass count N = max(1, ceil(REM_init / 7)); ROR always N=1.
- START sampled at edge E0. Passes occur at edges E1..EN. RESULT/ZERO update at EN. DONE is high between EN and EN+1. IDLE is re-entered at EN+1.
- Earliest next accept is edge EN+2, since START must be sampled while in IDLE.
- Request-to-DONE latency is N cycles after E0. Busy window is N+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset values: after RESET, check RESULT=0x00, ZERO=1, BUSY=0, DONE=0. Then SLL DATA=0x91 AMOUNT=1 → RESULT=0x22, N=1, DONE one cycle after E0.
- SRL DATA=0x91 AMOUNT=3 → RESULT=0x12, N=1. SRA DATA=0x91 AMOUNT=10 → two passes (7 then 3), RESULT=0xFF, ZERO=0, BUSY high for 3 cycles.
- ROR DATA=0x91 AMOUNT=9 → amount reduced to 1, RESULT=0xC8, N=1. SLL DATA=0x91 AMOUNT=0 → RESULT=0x91, N=1.
- SLL DATA=0xFF AMOUNT=255 → N=37, RESULT=0x00, ZERO=1. START pulses injected during SHIFT and DONE are ignored: no second DONE, RESULT unchanged.
- RESET asserted on the 2nd pass of SRA DATA=0x80 AMOUNT=20 → no DONE, all outputs at reset values the next cycle. A START two cycles later completes normally.
- Back-to-back: START held high continuously with DATA=0x01, SLL, AMOUNT=1 → requests accepted every 3 cycles, each DONE with RESULT=0x02.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: chains 0..7-position barrel passes over an
// 8-bit accumulator until the full 8-bit shift amount has been consumed.
module shift_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] OP,
    input  logic [7:0] DATA,
    input  logic [7:0] AMOUNT,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic       ZERO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROR = 2'd3
    } op_t;

    state_t      r_state;
    logic [7:0]  r_acc;
    logic [7:0]  r_rem;
    op_t         r_opr;
    logic [7:0]  r_result;
    logic        r_zero;
    logic        r_busy;
    logic        r_done;

    logic [2:0]  w_step;
    logic [15:0] w_rot;
    logic [7:0]  w_pass;
    logic [7:0]  w_rem_next;

    always_comb begin
        w_step     = (r_rem > 8'd7) ? 3'd7 : r_rem[2:0];
        w_rot      = {r_acc, r_acc} >> w_step;
        w_rem_next = r_rem - {5'd0, w_step};
        w_pass     = r_acc;
        case (r_opr)
            OP_SLL:  w_pass = r_acc << w_step;
            OP_SRL:  w_pass = r_acc >> w_step;
            // Sign fill comes from the accumulator, so it survives across passes
            OP_SRA:  w_pass = $signed(r_acc) >>> w_step;
            OP_ROR:  w_pass = w_rot[7:0];
            default: w_pass = r_acc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_rem    <= '0;
            r_opr    <= OP_SLL;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_acc   <= DATA;
                        r_opr   <= op_t'(OP);
                        // Rotation is periodic in 8, so only one pass is ever needed
                        r_rem   <= (op_t'(OP) == OP_ROR) ? {5'd0, AMOUNT[2:0]} : AMOUNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_pass;
                    r_rem <= w_rem_next;
                    if (w_rem_next == 8'd0) begin
                        r_result <= w_pass;
                        r_zero   <= (w_pass == 8'd0);
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;
    assign ZERO   = r_zero;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random requests
// compared against an arithmetic reference model of the shift result and pass count.
module tb_shift_sequencer;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [1:0] OP;
    logic [7:0] DATA;
    logic [7:0] AMOUNT;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic       ZERO;

    int total = 0;
    int bad   = 0;

    shift_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .OP     (OP),
        .DATA   (DATA),
        .AMOUNT (AMOUNT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .ZERO   (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
        int v;
        int s;
        int r;
        v = int'(d);
        case (op)
            2'd0: ref_result = (a >= 8) ? 8'h00 : 8'((v << a) & 255);
            2'd1: ref_result = (a >= 8) ? 8'h00 : 8'(v >> a);
            2'd2: begin
                s = d[7] ? v - 256 : v;
                r = (a > 7) ? 7 : int'(a);
                ref_result = 8'((s >>> r) & 255);
            end
            default: begin
                r = int'(a) % 8;
                ref_result = 8'(((v >> r) | (v << (8 - r))) & 255);
            end
        endcase
    endfunction

    function automatic int ref_passes(input logic [1:0] op, input logic [7:0] a);
        if (op == 2'd3 || a == 8'd0) ref_passes = 1;
        else ref_passes = (int'(a) + 6) / 7;
    endfunction

    task automatic req(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a, input bit inject);
        logic [7:0] exp_r;
        int         n_exp;
        int         k;
        bit         seen;
        bit         busy_low;
        bit         extra_done;
        exp_r      = ref_result(op, d, a);
        n_exp      = ref_passes(op, a);
        @(negedge CLK);
        START  = 1'b1;
        OP     = op;
        DATA   = d;
        AMOUNT = a;
        @(negedge CLK);
        if (inject) begin
            OP     = 2'($urandom);
            DATA   = 8'($urandom);
            AMOUNT = 8'($urandom);
        end else begin
            START = 1'b0;
        end
        chk("busy_after_accept", 32'(BUSY), 32'd1);
        chk("done_after_accept", 32'(DONE), 32'd0);
        k        = 0;
        seen     = 1'b0;
        busy_low = 1'b0;
        while (!seen && k < 300) begin
            @(negedge CLK);
            k++;
            if (!BUSY) busy_low = 1'b1;
            if (DONE) seen = 1'b1;
        end
        chk("latency", 32'(k), 32'(n_exp));
        chk("busy_window", 32'(busy_low), 32'd0);
        chk("result", 32'(RESULT), 32'(exp_r));
        chk("zero", 32'(ZERO), 32'(exp_r == 8'h00));
        @(negedge CLK);
        START = 1'b0;
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_done", 32'(DONE), 32'd0);
        if (inject) begin
            extra_done = 1'b0;
            repeat (4) begin
                @(negedge CLK);
                if (DONE || BUSY) extra_done = 1'b1;
            end
            chk("ignored_start_no_done", 32'(extra_done), 32'd0);
            chk("ignored_start_result", 32'(RESULT), 32'(exp_r));
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [7:0] bnd [6];
        logic [7:0] amt;
        bit         any_done;
        bnd = '{8'd0, 8'd7, 8'd8, 8'd14, 8'd15, 8'd255};

        RESET  = 1'b1;
        START  = 1'b0;
        OP     = 2'd0;
        DATA   = 8'h00;
        AMOUNT = 8'h00;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_result", 32'(RESULT), 32'h00);
        chk("rst_zero", 32'(ZERO), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);

        req(2'd0, 8'h91, 8'd1, 1'b0);
        chk("sll_91_1", 32'(RESULT), 32'h22);
        req(2'd1, 8'h91, 8'd3, 1'b0);
        chk("srl_91_3", 32'(RESULT), 32'h12);
        req(2'd2, 8'h91, 8'd10, 1'b0);
        chk("sra_91_10", 32'(RESULT), 32'hFF);
        req(2'd3, 8'h91, 8'd9, 1'b0);
        chk("ror_91_9", 32'(RESULT), 32'hC8);
        req(2'd0, 8'h91, 8'd0, 1'b0);
        chk("sll_91_0", 32'(RESULT), 32'h91);
        req(2'd0, 8'hFF, 8'd255, 1'b1);
        chk("sll_ff_255", 32'(RESULT), 32'h00);

        // Reset lands on the second pass of a three-pass SRA
        @(negedge CLK);
        START  = 1'b1;
        OP     = 2'd2;
        DATA   = 8'h80;
        AMOUNT = 8'd20;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort_result", 32'(RESULT), 32'h00);
        chk("abort_zero", 32'(ZERO), 32'd1);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        any_done = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE) any_done = 1'b1;
        end
        chk("abort_no_done", 32'(any_done), 32'd0);
        req(2'd2, 8'h80, 8'd20, 1'b0);

        // START coincident with RESET must be dropped
        @(negedge CLK);
        RESET = 1'b1;
        START = 1'b1;
        OP    = 2'd0;
        DATA  = 8'h55;
        AMOUNT = 8'd3;
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        chk("rst_start_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        chk("rst_start_busy2", 32'(BUSY), 32'd0);

        // START held high: accepted every third edge
        @(negedge CLK);
        START  = 1'b1;
        OP     = 2'd0;
        DATA   = 8'h01;
        AMOUNT = 8'd1;
        for (int unsigned j = 0; j < 12; j++) begin
            @(negedge CLK);
            chk("b2b_done", 32'(DONE), 32'((j % 3) == 1));
            if (DONE) chk("b2b_result", 32'(RESULT), 32'h02);
        end
        START = 1'b0;
        repeat (3) @(negedge CLK);

        for (int unsigned i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) amt = bnd[$urandom_range(0, 5)];
            else amt = 8'($urandom);
            req(2'($urandom), 8'($urandom), amt, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
